// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg: size/state encodings and byte-lane helpers shared by the memory sequencer and the load extender.
package sparc_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  localparam logic RW_READ = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR, S_HOLD} state_t;
  function automatic logic [1:0] sz_last(input logic [1:0] t);
    return t == SZ_BYTE ? 2'd0 : t == SZ_HALF ? 2'd1 : 2'd3;
  endfunction
  function automatic logic sz_bad(input logic [1:0] t, input logic [1:0] a);
    return t == SZ_RSVD || (t == SZ_HALF && a[0]) || (t == SZ_WORD && a != 2'b00);
  endfunction
  // big-endian lane: transfer k carries operand byte (last-k) counted from the LSB
  function automatic logic [7:0] op_byte(input logic [31:0] d, input logic [1:0] last, input logic [1:0] k);
    logic [1:0] s;
    s = last - k;
    return d[{s, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/sparc_load_extend.sv
// sparc_load_extend: sign/zero-extends an assembled big-endian load to 32 bits by access size.
module sparc_load_extend import sparc_mem_pkg::*; (
  input  logic [31:0] i_asm,
  input  logic [1:0]  i_type,
  input  logic        i_sign,
  output logic [31:0] o_data
);
  assign o_data = i_type == SZ_BYTE ? {{24{i_sign & i_asm[7]}}, i_asm[7:0]} :
                  i_type == SZ_HALF ? {{16{i_sign & i_asm[15]}}, i_asm[15:0]} : i_asm;
endmodule

// File: rtl/sparc_mem_ctrl.sv
// sparc_mem_ctrl: MOV/MOC sequencer splitting byte/half/word accesses into big-endian byte RAM cycles.
module sparc_mem_ctrl import sparc_mem_pkg::*; #(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MOV,
  input  logic              r_w,
  input  logic [1:0]        mem_type,
  input  logic              sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              MOC,
  output logic              MAE,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);
  state_t r_state;
  logic [ADDR_W-1:0] r_base;
  logic [31:0] r_data;
  logic [1:0] r_type, r_last, r_k, r_lat;
  logic r_rw, r_sign;
  logic [23:0] r_asm;
  logic [31:0] w_asm, w_ext;
  logic [1:0] w_k1;
  logic [ADDR_W-1:0] w_addr1;
  logic w_unused;
  assign w_asm = {r_asm, ram_rdata};
  assign w_k1 = r_k + 2'd1;
  assign w_addr1 = r_base + ADDR_W'(w_k1);
  assign busy = r_state != S_IDLE;
  assign w_unused = ^addr[31:ADDR_W];
  sparc_load_extend u_ext (.i_asm(w_asm), .i_type(r_type), .i_sign(r_sign), .o_data(w_ext));
  // outputs are registered on the edge entering the state they belong to
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state <= S_IDLE;
      r_k <= 2'd0;
      r_lat <= 2'd0;
      data_out <= 32'd0;
      MOC <= 1'b0;
      MAE <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= 8'd0;
    end else begin
      MOC <= 1'b0;
      MAE <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (r_state)
        S_IDLE: if (MOV) begin
          r_base <= addr[ADDR_W-1:0];
          r_data <= data_in;
          r_type <= mem_type;
          r_rw <= r_w;
          r_sign <= sign;
          r_last <= sz_last(mem_type);
          r_k <= 2'd0;
          if (sz_bad(mem_type, addr[1:0])) begin
            r_state <= S_ERR;
            MOC <= 1'b1;
            MAE <= 1'b1;
          end else begin
            r_state <= S_ISSUE;
            ram_en <= 1'b1;
            ram_we <= r_w != RW_READ;
            ram_addr <= addr[ADDR_W-1:0];
            ram_wdata <= op_byte(data_in, sz_last(mem_type), 2'd0);
          end
        end
        S_ISSUE: if (r_rw == RW_READ) begin
          r_state <= S_WAIT;
          r_lat <= 2'(RD_LAT);
        end else if (r_k == r_last) begin
          r_state <= S_DONE;
          MOC <= 1'b1;
        end else begin
          r_k <= w_k1;
          ram_en <= 1'b1;
          ram_we <= 1'b1;
          ram_addr <= w_addr1;
          ram_wdata <= op_byte(r_data, r_last, w_k1);
        end
        S_WAIT: begin
          r_lat <= r_lat - 2'd1;
          if (r_lat == 2'd1) begin
            r_asm <= w_asm[23:0];
            if (r_k == r_last) begin
              r_state <= S_DONE;
              MOC <= 1'b1;
              data_out <= w_ext;
            end else begin
              r_state <= S_ISSUE;
              r_k <= w_k1;
              ram_en <= 1'b1;
              ram_addr <= w_addr1;
            end
          end
        end
        S_DONE, S_ERR: r_state <= S_HOLD;
        S_HOLD: if (!MOV) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sparc_mem_ctrl.sv
// tb_sparc_mem_ctrl: table-driven requests against a byte RAM model with write and result scoreboards.
module tb_sparc_mem_ctrl;
  localparam int AW = 9;
  logic Clk = 1'b0, Clr = 1'b1, MOV = 1'b0, r_w = 1'b0, sign = 1'b0;
  logic [1:0] mem_type = 2'b00;
  logic [31:0] addr = 32'd0, data_in = 32'd0;
  logic [31:0] data_out;
  logic MOC, MAE, busy, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata = 8'd0;
  logic [7:0] mem [0:511] = '{default: 8'h00};

  typedef struct {logic rw; logic [1:0] ty; logic sg; logic [31:0] ad; logic [31:0] dt; int lat; logic mae; logic [31:0] dout; int nen;} vec_t;
  typedef struct {logic [AW-1:0] a; logic [7:0] b;} wr_t;
  typedef struct {int lat; logic mae; logic [31:0] dout;} res_t;
  wr_t exp_wr[$], act_wr[$];
  res_t exp_res[$];
  vec_t tbl[18];
  int checks = 0, errors = 0;
  int en_cnt = 0, moc_cnt = 0, we_bad = 0;

  always #5 Clk = ~Clk;

  sparc_mem_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dut (
    .Clk(Clk), .Clr(Clr), .MOV(MOV), .r_w(r_w), .mem_type(mem_type), .sign(sign),
    .addr(addr), .data_in(data_in), .data_out(data_out), .MOC(MOC), .MAE(MAE), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge Clk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        act_wr.push_back('{ram_addr, ram_wdata});
      end else ram_rdata <= mem[ram_addr];
    end
    if (MOC) moc_cnt <= moc_cnt + 1;
    if (ram_we && !ram_en) we_bad <= we_bad + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_writes(input string nm);
    wr_t e, a;
    chk({nm, "_wr_count"}, act_wr.size(), exp_wr.size());
    while (act_wr.size() > 0 && exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      a = act_wr.pop_front();
      chk({nm, "_wr_addr"}, 32'(a.a), 32'(e.a));
      chk({nm, "_wr_byte"}, 32'(a.b), 32'(e.b));
    end
    act_wr.delete();
    exp_wr.delete();
  endtask

  task automatic req(input vec_t v, input int hold, input string nm);
    int cyc, e0, m0, n;
    res_t r;
    n = v.ty == 2'b00 ? 1 : v.ty == 2'b01 ? 2 : 4;
    if (!v.mae && !v.rw)
      for (int k = 0; k < n; k++) exp_wr.push_back('{v.ad[AW-1:0] + AW'(k), 8'(v.dt >> (8 * (n - 1 - k)))});
    exp_res.push_back('{v.lat, v.mae, v.dout});
    e0 = en_cnt;
    @(negedge Clk);
    r_w = v.rw; mem_type = v.ty; sign = v.sg; addr = v.ad; data_in = v.dt; MOV = 1'b1;
    @(negedge Clk);
    cyc = 1;
    addr = $urandom; data_in = $urandom; mem_type = 2'($urandom); sign = ~v.sg; r_w = ~v.rw;
    while (MOC !== 1'b1 && cyc < 60) begin
      @(negedge Clk);
      cyc++;
    end
    r = exp_res.pop_front();
    m0 = moc_cnt;
    chk({nm, "_latency"}, cyc, r.lat);
    chk({nm, "_mae"}, 32'(MAE), 32'(r.mae));
    chk({nm, "_data_out"}, data_out, r.dout);
    repeat (hold) @(negedge Clk);
    chk({nm, "_busy_hold"}, 32'(busy), 32'd1);
    MOV = 1'b0;
    repeat (3) @(negedge Clk);
    chk({nm, "_moc_pulses"}, moc_cnt - m0, 32'd1);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    chk({nm, "_ram_cycles"}, en_cnt - e0, v.nen);
    chk_writes(nm);
  endtask

  initial begin
    int m0;
    tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 5, 1'b0, 32'h0000_0000, 4};
    tbl[1]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         9, 1'b0, 32'hDEAD_BEEF, 4};
    tbl[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h1234_5680, 2, 1'b0, 32'hDEAD_BEEF, 1};
    tbl[3]  = '{1'b1, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         3, 1'b0, 32'hFFFF_FF80, 1};
    tbl[4]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         3, 1'b0, 32'h0000_0080, 1};
    tbl[5]  = '{1'b1, 2'b01, 1'b1, 32'h0000_0010, 32'h0,         5, 1'b0, 32'hFFFF_DEAD, 2};
    tbl[6]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         5, 1'b0, 32'h0000_BE80, 2};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0012, 32'h0,         1, 1'b1, 32'h0000_BE80, 0};
    tbl[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h5555_5555, 1, 1'b1, 32'h0000_BE80, 0};
    tbl[9]  = '{1'b1, 2'b11, 1'b1, 32'h0000_0020, 32'h0,         1, 1'b1, 32'h0000_BE80, 0};
    tbl[10] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FE20, 32'hCAFE_F00D, 5, 1'b0, 32'h0000_BE80, 4};
    tbl[11] = '{1'b1, 2'b10, 1'b1, 32'h0000_0020, 32'h0,         9, 1'b0, 32'hCAFE_F00D, 4};
    tbl[12] = '{1'b1, 2'b01, 1'b1, 32'h0000_0022, 32'h0,         5, 1'b0, 32'hFFFF_F00D, 2};
    tbl[13] = '{1'b1, 2'b00, 1'b1, 32'h0000_0021, 32'h0,         3, 1'b0, 32'hFFFF_FFFE, 1};
    tbl[14] = '{1'b0, 2'b01, 1'b1, 32'h0000_0030, 32'hAAAA_8001, 3, 1'b0, 32'hFFFF_FFFE, 2};
    tbl[15] = '{1'b1, 2'b01, 1'b0, 32'h0000_0030, 32'h0,         5, 1'b0, 32'h0000_8001, 2};
    tbl[16] = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h5566_7788, 5, 1'b0, 32'h0000_0000, 4};
    tbl[17] = '{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         9, 1'b0, 32'h5566_7788, 4};
    repeat (3) @(negedge Clk);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_moc_mae", {30'd0, MOC, MAE}, 32'd0);
    chk("rst_ram_ctl", {30'd0, ram_en, ram_we}, 32'd0);
    chk("rst_ram_bus", {15'd0, ram_addr, ram_wdata}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Clr = 1'b0;
    for (int i = 0; i < 16; i++) req(tbl[i], (i % 3) * 3, $sformatf("vec%0d", i));
    @(negedge Clk);
    r_w = 1'b0; mem_type = 2'b10; addr = 32'h40; data_in = 32'h1122_3344; MOV = 1'b1;
    exp_wr.push_back('{9'h040, 8'h11});
    exp_wr.push_back('{9'h041, 8'h22});
    @(negedge Clk);
    @(negedge Clk);
    Clr = 1'b1; MOV = 1'b0;
    @(negedge Clk);
    chk("abort_data_out", data_out, 32'd0);
    chk("abort_ctl", {28'd0, MOC, MAE, ram_en, ram_we}, 32'd0);
    chk("abort_bus", {15'd0, ram_addr, ram_wdata}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    Clr = 1'b0;
    m0 = moc_cnt;
    repeat (4) @(negedge Clk);
    chk("abort_no_moc", moc_cnt - m0, 32'd0);
    chk("abort_mem", {mem[9'h40], mem[9'h41], mem[9'h42], mem[9'h43]}, 32'h1122_0000);
    chk_writes("abort");
    req(tbl[16], 6, "post_abort_store");
    req(tbl[17], 0, "post_abort_load");
    chk("we_without_en", we_bad, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sparc_mem_ctrl.md
Name: sparc_mem_ctrl

Overview:
Memory-access sequencer between the control unit's MOV/MOC handshake (address from MAR, data from MDR) and a byte-wide synchronous RAM. It breaks byte, halfword and word accesses into big-endian byte transfers. It applies sign or zero extension on loads, flags misaligned or reserved accesses as MAE, and returns a one-cycle MOC pulse on completion.

Parameters:
ADDR_W, 9, RAM byte-address width; the low ADDR_W bits of addr are used.
RD_LAT, 1, RAM read latency in cycles (legal range 1..3).

Ports:
Clk  in  1  system clock; all logic is on the rising edge.
Clr  in  1  synchronous, active-high reset.
MOV  in  1  memory-operation request; held high by the CU until it sees MOC.
r_w  in  1  1 = read (load), 0 = write (store).
type  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
sign  in  1  1 = sign-extend on loads; ignored on stores.
addr  in  32  byte address (MAR).
data_in  in  32  store data (MDR); the operand is right-justified.
data_out  out  32  load result, extended to 32 bits.
MOC  out  1  memory-operation-complete pulse.
MAE  out  1  misaligned/illegal access; valid in the same cycle as MOC.
busy  out  1  high in every state except IDLE.
ram_en  out  1  RAM cycle enable.
ram_we  out  1  RAM write enable; only meaningful while ram_en is high.
ram_addr  out  ADDR_W  RAM byte address.
ram_wdata  out  8  RAM write byte.
ram_rdata  in  8  RAM read byte.

Behaviour:
- Reset (Clr=1 at an edge):
  - Next state is IDLE; the byte counter and latency counter clear.
  - data_out, MOC, MAE, ram_en, ram_we, ram_addr, ram_wdata all become 0.
  - Clr mid-access aborts immediately. Bytes already written stay in RAM, and no MOC is produced.
- States: IDLE, ISSUE, WAIT, DONE, ERR, HOLD.
- IDLE:
  - On an edge with MOV=1, latch addr, data_in, type, r_w, sign.
  - Set n = 1/2/4 bytes for type 00/01/10 and k = 0.
  - Go to ERR if type=11, or type=01 with addr[0]=1, or type=10 with addr[1:0]!=0. Otherwise go to ISSUE.
- ISSUE (one cycle per byte):
  - ram_en=1, ram_we=~r_w, ram_addr=addr_latched+k.
  - ram_wdata = operand byte k, big-endian: k=0 is the most significant byte of the n-byte operand.
  - Writes: if k=n-1 go to DONE, else k++ and stay in ISSUE.
  - Reads: go to WAIT with the latency counter at RD_LAT.
- WAIT:
  - ram_en=0 and the latency counter decrements.
  - On the edge where it reaches 0, shift ram_rdata into the low byte of the assembly register.
  - Then go to ISSUE with k++ if k<n-1, else go to DONE.
- DONE:
  - MOC=1 for exactly one cycle.
  - For reads, data_out updates at the edge entering DONE: zero- or sign-extended from bit 7/15 per type and sign.
  - data_out holds until the next successful read completes.
- ERR:
  - MOC=1 and MAE=1 for one cycle.
  - No RAM cycle is issued, and data_out is unchanged.
- HOLD: wait for MOV=0, then go to IDLE. This guarantees one MOC per request even if the CU is slow to drop MOV.
- Latency, counted as cycles from the MOV sampling edge to the MOC-high cycle:
  - write: n+1
  - read: n*(1+RD_LAT)+1
  - error: 1
- Address arithmetic: ram_addr wraps modulo 2^ADDR_W. Misalignment is checked on the full addr; the upper bits beyond ADDR_W are ignored otherwise.
- Input changes on addr, data_in, type, r_w and sign after the latching edge have no effect.
- MOV rising while busy is ignored until the controller is back in IDLE.
- ram_we is never high unless ram_en is high.

Decomposition:
- Shared package sparc_mem_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11
  - state encoding constants
  - RW_READ=1'b1
- One natural sub-module, sparc_load_extend: combinational 32-bit assembly register + type + sign -> extended data_out. It is reused later by the cache path.

Test Plan:
1. Store word: addr=0x10, data_in=0xDEADBEEF, r_w=0, type=10, MOV=1 -> ram writes 0xDE@0x10, 0xAD@0x11, 0xBE@0x12, 0xEF@0x13 on cycles 1-4; MOC high on cycle 5, MAE=0.
2. Load signed byte: RAM[0x13]=0x80, type=00, sign=1, RD_LAT=1 -> MOC on cycle 3, data_out=0xFFFFFF80. Repeat with sign=0 -> 0x00000080.
3. Load halfword: RAM[0x10..0x11]=0xDE,0xAD, sign=1 -> MOC on cycle 5, data_out=0xFFFFDEAD. Word load from 0x10 -> 0xDEADBEEF, MOC on cycle 9.
4. Misaligned: type=10 addr=0x12, and type=01 addr=0x11, and type=11 -> MOC=MAE=1 on cycle 1, ram_en never high, data_out unchanged.
5. Handshake: hold MOV=1 for 6 cycles after MOC -> exactly one MOC pulse, busy=1 until MOV drops, then IDLE. Back-to-back requests each get exactly one MOC.
6. Clr asserted on cycle 2 of a word store -> only bytes 0-1 written; all outputs 0 next cycle; no MOC; a following store completes normally.
